// File: rtl/vga_timing_pkg.sv
// Shared timing types, default VGA 640x480 timing and end-count helpers.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      LOW  = 2'b00,
      BP   = 2'b01,
      DISP = 2'b10,
      FP   = 2'b11
   } axis_state_e;

   localparam int unsigned DEF_CLK_PER_PIX = 4;
   localparam int unsigned DEF_H_SYNC      = 96;
   localparam int unsigned DEF_H_BP        = 48;
   localparam int unsigned DEF_H_ACT       = 640;
   localparam int unsigned DEF_H_FP        = 16;
   localparam int unsigned DEF_V_SYNC      = 2;
   localparam int unsigned DEF_V_BP        = 29;
   localparam int unsigned DEF_V_ACT       = 480;
   localparam int unsigned DEF_V_FP        = 10;
   localparam int unsigned DEF_SCALE_SHIFT = 2;
   localparam int unsigned DEF_ADDR_W      = 15;

   localparam int unsigned H_TOT =
      (DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP) * DEF_CLK_PER_PIX;
   localparam int unsigned V_TOT = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

   // Last count of each axis state, in counter units
   typedef struct packed {
      logic [31:0] low_end;
      logic [31:0] bp_end;
      logic [31:0] disp_end;
      logic [31:0] fp_end;
   } axis_ends_t;

   // Derive per-state last counts from segment lengths and counts per unit
   function automatic axis_ends_t axis_ends(input int unsigned sync_len,
                                            input int unsigned bp_len,
                                            input int unsigned act_len,
                                            input int unsigned fp_len,
                                            input int unsigned unit);
      axis_ends_t e;
      e.low_end  = 32'(sync_len * unit - 1);
      e.bp_end   = 32'((sync_len + bp_len) * unit - 1);
      e.disp_end = 32'((sync_len + bp_len + act_len) * unit - 1);
      e.fp_end   = 32'((sync_len + bp_len + act_len + fp_len) * unit - 1);
      return e;
   endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One sync/blanking sequencer for a single scan axis (horizontal or vertical).
module vga_axis_fsm
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] count,
   input  logic             advance,
   input  logic [CNT_W-1:0] end_low,
   input  logic [CNT_W-1:0] end_bp,
   input  logic [CNT_W-1:0] end_disp,
   input  logic [CNT_W-1:0] end_fp,
   output logic             sync_n,
   output logic             active
);

   axis_state_e state;
   axis_state_e state_nxt;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= LOW;
      else        state <= state_nxt;
   end

   // Leave each state on the clock after its last count
   always_comb begin
      state_nxt = state;
      if (advance) begin
         case (state)
            LOW:     if (count == end_low)  state_nxt = BP;
            BP:      if (count == end_bp)   state_nxt = DISP;
            DISP:    if (count == end_disp) state_nxt = FP;
            FP:      if (count == end_fp)   state_nxt = LOW;
            default: state_nxt = LOW;
         endcase
      end
   end

   // Moore outputs: sync low only in LOW, active only in DISP
   always_comb begin
      sync_n = 1'b1;
      active = 1'b0;
      case (state)
         LOW:     sync_n = 1'b0;
         DISP:    active = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan sequencer: H/V counters, sync generation, frame-buffer read schedule, RGB output.
module vga_scan_controller
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_PER_PIX = DEF_CLK_PER_PIX,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BP        = DEF_H_BP,
   parameter int unsigned H_ACT       = DEF_H_ACT,
   parameter int unsigned H_FP        = DEF_H_FP,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BP        = DEF_V_BP,
   parameter int unsigned V_ACT       = DEF_V_ACT,
   parameter int unsigned V_FP        = DEF_V_FP,
   parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              pix_rd,
   output logic [ADDR_W-1:0] pix_addr,
   input  logic [2:0]        pix_data,
   output logic              HSYNC,
   output logic              VSYNC,
   output logic              VGA_R,
   output logic              VGA_G,
   output logic              VGA_B,
   output logic              frame_start
);

   localparam axis_ends_t  H_E = axis_ends(H_SYNC, H_BP, H_ACT, H_FP, CLK_PER_PIX);
   localparam axis_ends_t  V_E = axis_ends(V_SYNC, V_BP, V_ACT, V_FP, 1);
   localparam int unsigned H_TOTAL     = (H_SYNC + H_BP + H_ACT + H_FP) * CLK_PER_PIX;
   localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int unsigned HC_W        = $clog2(H_TOTAL);
   localparam int unsigned VC_W        = $clog2(V_TOTAL);
   // Read strobe leads the first visible clk by 2 (address reg + sync memory),
   // so the decision to issue is taken one clk earlier still.
   localparam int unsigned DISP_START  = (H_SYNC + H_BP) * CLK_PER_PIX;
   localparam int unsigned RD_PRE      = DISP_START - 3;
   localparam int unsigned RD_PRE_LAST = RD_PRE + CLK_PER_PIX * (H_ACT - 1);
   localparam int unsigned PH_W        = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
   localparam int unsigned X_W         = $clog2(H_ACT + 1);
   localparam int unsigned YS_W        = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
   localparam int unsigned Y_SUB_LAST  = (1 << SCALE_SHIFT) - 1;
   localparam int unsigned ROW_STRIDE  = H_ACT >> SCALE_SHIFT;

   logic              running, running_d;
   logic [HC_W-1:0]   h_count, h_d;
   logic [VC_W-1:0]   v_count, v_d;
   logic              h_wrap, v_last;
   logic              h_sync_n, h_active, v_sync_n, v_active;
   logic              rd_window, issue;
   logic [PH_W-1:0]   phase, phase_d;
   logic [X_W-1:0]    x_q;
   logic [YS_W-1:0]   y_sub;
   logic [ADDR_W-1:0] row_base;
   logic              rd_d1;
   logic [2:0]        rgb_q;

   // Next counter and run-flag values; enable is only honoured at frame boundaries
   always_comb begin
      h_wrap    = (h_count == HC_W'(H_E.fp_end));
      v_last    = (v_count == VC_W'(V_E.fp_end));
      running_d = running;
      h_d       = h_count;
      v_d       = v_count;
      if (!running) begin
         running_d = enable;
         h_d       = '0;
         v_d       = '0;
      end else begin
         h_d = h_wrap ? '0 : h_count + HC_W'(1);
         if (h_wrap) v_d = v_last ? '0 : v_count + VC_W'(1);
         if (h_wrap && v_last) running_d = enable;
      end
   end

   // Counters, run flag and frame-start pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         running     <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         frame_start <= 1'b0;
      end else begin
         running     <= running_d;
         h_count     <= h_d;
         v_count     <= v_d;
         frame_start <= running_d && (h_d == '0) && (v_d == '0);
      end
   end

   vga_axis_fsm #(.CNT_W(HC_W)) u_h_fsm (
      .clk      (clk),
      .reset    (reset),
      .count    (h_count),
      .advance  (running),
      .end_low  (HC_W'(H_E.low_end)),
      .end_bp   (HC_W'(H_E.bp_end)),
      .end_disp (HC_W'(H_E.disp_end)),
      .end_fp   (HC_W'(H_E.fp_end)),
      .sync_n   (h_sync_n),
      .active   (h_active)
   );

   vga_axis_fsm #(.CNT_W(VC_W)) u_v_fsm (
      .clk      (clk),
      .reset    (reset),
      .count    (v_count),
      .advance  (running && h_wrap),
      .end_low  (VC_W'(V_E.low_end)),
      .end_bp   (VC_W'(V_E.bp_end)),
      .end_disp (VC_W'(V_E.disp_end)),
      .end_fp   (VC_W'(V_E.fp_end)),
      .sync_n   (v_sync_n),
      .active   (v_active)
   );

   assign HSYNC = h_sync_n;
   assign VSYNC = v_sync_n;

   // Issue one read every CLK_PER_PIX clks inside the read window of an active line
   always_comb begin
      rd_window = running && v_active &&
                  (h_count >= HC_W'(RD_PRE)) && (h_count <= HC_W'(RD_PRE_LAST));
      issue     = rd_window && (phase == '0);
      phase_d   = '0;
      if (rd_window) phase_d = (phase == PH_W'(CLK_PER_PIX - 1)) ? '0 : phase + PH_W'(1);
   end

   // Read strobe, column counter and registered address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= '0;
         x_q      <= '0;
         pix_rd   <= 1'b0;
         pix_addr <= '0;
         rd_d1    <= 1'b0;
      end else begin
         phase  <= phase_d;
         pix_rd <= issue;
         rd_d1  <= pix_rd;
         if (issue) pix_addr <= row_base + ADDR_W'(x_q >> SCALE_SHIFT);
         if (!running || h_wrap) x_q <= '0;
         else if (issue)         x_q <= x_q + X_W'(1);
      end
   end

   // Row base accumulates one stored-image row every 2**SCALE_SHIFT active lines
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_sub    <= '0;
         row_base <= '0;
      end else if (!running || (h_wrap && v_last)) begin
         y_sub    <= '0;
         row_base <= '0;
      end else if (h_wrap && v_active) begin
         if (y_sub == YS_W'(Y_SUB_LAST)) begin
            y_sub    <= '0;
            row_base <= row_base + ADDR_W'(ROW_STRIDE);
         end else begin
            y_sub <= y_sub + YS_W'(1);
         end
      end
   end

   // Capture memory data; blank on the last display clk and whenever outside display
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_q <= '0;
      end else if (rd_d1) begin
         rgb_q <= pix_data;
      end else if (!(running && h_active && v_active) ||
                   (h_count == HC_W'(H_E.disp_end))) begin
         rgb_q <= '0;
      end
   end

   assign VGA_R = rgb_q[2];
   assign VGA_G = rgb_q[1];
   assign VGA_B = rgb_q[0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: default-timing instance for line/sync periods, reduced-timing instance for frames.
module tb_vga_scan_controller;

   localparam int unsigned AW   = 15;
   localparam int unsigned S_HT = 56;   // (2+2+8+2)*4
   localparam int unsigned S_VT = 14;   // 2+2+8+2

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // reduced-timing instance
   logic          s_reset, s_enable, s_pix_rd, s_hs, s_vs, s_r, s_g, s_b, s_fs;
   logic [AW-1:0] s_pix_addr;
   logic [2:0]    s_pix_data = 3'd0;
   // default-timing instance
   logic          d_reset, d_enable, d_pix_rd, d_hs, d_vs, d_r, d_g, d_b, d_fs;
   logic [AW-1:0] d_pix_addr;
   logic [2:0]    d_pix_data = 3'd0;

   vga_scan_controller #(
      .CLK_PER_PIX(4), .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
      .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2), .SCALE_SHIFT(1), .ADDR_W(AW)
   ) u_small (
      .clk(clk), .reset(s_reset), .enable(s_enable), .pix_rd(s_pix_rd),
      .pix_addr(s_pix_addr), .pix_data(s_pix_data), .HSYNC(s_hs), .VSYNC(s_vs),
      .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .frame_start(s_fs)
   );

   vga_scan_controller u_def (
      .clk(clk), .reset(d_reset), .enable(d_enable), .pix_rd(d_pix_rd),
      .pix_addr(d_pix_addr), .pix_data(d_pix_data), .HSYNC(d_hs), .VSYNC(d_vs),
      .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .frame_start(d_fs)
   );

   // synchronous ROM models: data = addr[2:0], one clk after the strobe
   always @(posedge clk) begin
      if (s_pix_rd) s_pix_data <= s_pix_addr[2:0];
      if (d_pix_rd) d_pix_data <= d_pix_addr[2:0];
   end

   typedef struct {
      int         v;
      int         h;
      logic       hs;
      logic       vs;
      logic       rd;
      int         addr;
      logic [2:0] rgb;
      logic       fs;
   } vec_t;

   vec_t vq[$];
   int errors = 0;
   int checks = 0;
   int p, hs_low, hs_high, vs_low, rd_cnt, fs_cnt;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input int v, input int h, input logic hs, input logic vs,
                      input logic rd, input int addr, input logic [2:0] rgb, input logic fs);
      vec_t e;
      e.v = v; e.h = h; e.hs = hs; e.vs = vs; e.rd = rd; e.addr = addr; e.rgb = rgb; e.fs = fs;
      vq.push_back(e);
   endtask

   task automatic sample_s();
      if (!s_hs) hs_low++; else hs_high++;
      if (!s_vs) vs_low++;
      if (s_pix_rd) rd_cnt++;
      if (s_fs) fs_cnt++;
   endtask

   task automatic new_frame();
      p = 0; hs_low = 0; hs_high = 0; vs_low = 0; rd_cnt = 0; fs_cnt = 0;
      sample_s();
   endtask

   task automatic adv_s();
      @(posedge clk); #1;
      p++;
      sample_s();
   endtask

   task automatic run_to_s(input int target);
      while (p < target) adv_s();
   endtask

   task automatic wait_fs(input bit use_def, input int max_cyc, output bit found);
      found = 1'b0;
      for (int i = 0; i < max_cyc && !found; i++) begin
         @(posedge clk); #1;
         if (use_def ? d_fs : s_fs) found = 1'b1;
      end
   endtask

   initial begin
      bit found;
      int dh_low, dfs, drd;
      s_reset = 1'b0; s_enable = 1'b1;
      d_reset = 1'b0; d_enable = 1'b1;

      // v, h, hs, vs, rd, addr, rgb, fs
      add(0,  0,  0, 0, 0, 0,  3'd0, 1);
      add(0,  1,  0, 0, 0, 0,  3'd0, 0);
      add(0,  7,  0, 0, 0, 0,  3'd0, 0);
      add(0,  8,  1, 0, 0, 0,  3'd0, 0);
      add(0,  55, 1, 0, 0, 0,  3'd0, 0);
      add(1,  0,  0, 0, 0, 0,  3'd0, 0);
      add(1,  55, 1, 0, 0, 0,  3'd0, 0);
      add(2,  0,  0, 1, 0, 0,  3'd0, 0);
      add(3,  14, 1, 1, 0, 0,  3'd0, 0);
      add(4,  14, 1, 1, 1, 0,  3'd0, 0);
      add(4,  15, 1, 1, 0, 0,  3'd0, 0);
      add(4,  18, 1, 1, 1, 0,  3'd0, 0);
      add(4,  22, 1, 1, 1, 1,  3'd0, 0);
      add(4,  24, 1, 1, 0, 0,  3'd1, 0);
      add(4,  42, 1, 1, 1, 3,  3'd3, 0);
      add(4,  47, 1, 1, 0, 0,  3'd3, 0);
      add(4,  48, 1, 1, 0, 0,  3'd0, 0);
      add(6,  14, 1, 1, 1, 4,  3'd0, 0);
      add(6,  15, 1, 1, 0, 0,  3'd0, 0);
      add(6,  16, 1, 1, 0, 0,  3'd4, 0);
      add(11, 42, 1, 1, 1, 15, 3'd7, 0);
      add(11, 44, 1, 1, 0, 0,  3'd7, 0);
      add(11, 48, 1, 1, 0, 0,  3'd0, 0);
      add(12, 14, 1, 1, 0, 0,  3'd0, 0);
      add(13, 55, 1, 1, 0, 0,  3'd0, 0);

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_hs", s_hs, 0);
      check("rst_rd", s_pix_rd, 0);
      check("rst_rgb", {s_r, s_g, s_b}, 0);
      check("rst_fs", s_fs, 0);

      // default timing: line period and sync widths
      d_reset = 1'b1;
      wait_fs(1'b1, 5, found);
      check("def_first_fs", found, 1);
      dh_low = 0; dfs = 0; drd = 0;
      for (int i = 0; i <= 6400; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (i < 3200 && !d_hs) dh_low++;
         if (d_fs) dfs++;
         if (d_pix_rd) drd++;
         if (i == 383)  check("def_hs_383", d_hs, 0);
         if (i == 384)  check("def_hs_384", d_hs, 1);
         if (i == 3199) check("def_hs_3199", d_hs, 1);
         if (i == 3200) check("def_hs_3200", d_hs, 0);
         if (i == 6399) check("def_vs_6399", d_vs, 0);
         if (i == 6400) check("def_vs_6400", d_vs, 1);
      end
      check("def_hs_low_cnt", dh_low, 384);
      check("def_fs_cnt", dfs, 1);
      check("def_rd_blank_cnt", drd, 0);
      d_reset = 1'b0;

      // reduced timing: full frame against the vector table
      s_reset = 1'b1;
      wait_fs(1'b0, 5, found);
      check("s_first_fs", found, 1);
      new_frame();
      for (int k = 0; k < vq.size(); k++) begin
         string tag;
         run_to_s(vq[k].v * S_HT + vq[k].h);
         tag = $sformatf("v%0d_h%0d", vq[k].v, vq[k].h);
         check({tag, "_hs"}, s_hs, vq[k].hs);
         check({tag, "_vs"}, s_vs, vq[k].vs);
         check({tag, "_rd"}, s_pix_rd, vq[k].rd);
         if (vq[k].rd) check({tag, "_addr"}, s_pix_addr, vq[k].addr);
         check({tag, "_rgb"}, {s_r, s_g, s_b}, vq[k].rgb);
         check({tag, "_fs"}, s_fs, vq[k].fs);
      end
      run_to_s(S_HT * S_VT - 1);
      check("f1_hs_low_cnt", hs_low, 14 * 8);
      check("f1_vs_low_cnt", vs_low, 2 * S_HT);
      check("f1_rd_cnt", rd_cnt, 64);
      check("f1_fs_cnt", fs_cnt, 1);

      // frame wrap: both counters to 0 and frame_start in the same clk
      adv_s();
      check("wrap_fs", s_fs, 1);
      check("wrap_hs", s_hs, 0);
      check("wrap_vs", s_vs, 0);

      // drop enable mid-frame: frame completes, then idles
      new_frame();
      run_to_s(6 * S_HT);
      s_enable = 1'b0;
      run_to_s(S_HT * S_VT - 1);
      check("f2_last_hs", s_hs, 1);
      check("f2_rd_cnt", rd_cnt, 64);
      adv_s();
      check("idle_fs", s_fs, 0);
      check("idle_vs", s_vs, 0);
      new_frame();
      run_to_s(60);
      check("idle_hs_high_cnt", hs_high, 0);
      check("idle_rd_cnt", rd_cnt, 0);

      // re-raise enable: frame_start one clk later, counting restarts
      s_enable = 1'b1;
      adv_s();
      check("restart_fs", s_fs, 1);
      new_frame();
      run_to_s(7);
      check("restart_hs_7", s_hs, 0);
      adv_s();
      check("restart_hs_8", s_hs, 1);

      // mid-frame reset: immediate return to reset values
      run_to_s(5 * S_HT + 26);
      check("pre_rst_rd", s_pix_rd, 1);
      check("pre_rst_addr", s_pix_addr, 1);
      check("pre_rst_rgb", {s_r, s_g, s_b}, 1);
      s_reset = 1'b0;
      #1;
      check("midrst_hs", s_hs, 0);
      check("midrst_vs", s_vs, 0);
      check("midrst_rd", s_pix_rd, 0);
      check("midrst_addr", s_pix_addr, 0);
      check("midrst_rgb", {s_r, s_g, s_b}, 0);
      repeat (2) @(posedge clk);
      #1;
      s_reset = 1'b1;
      wait_fs(1'b0, 4, found);
      check("post_rst_fs", found, 1);
      new_frame();
      run_to_s(8);
      check("post_rst_hs_8", s_hs, 1);
      run_to_s(4 * S_HT + 14);
      check("post_rst_rd", s_pix_rd, 1);
      check("post_rst_addr", s_pix_addr, 0);
      check("post_rst_vs", s_vs, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
